mips_mem_arb: RTL and testbench



---
 rtl/mips_mem_arb.sv | 132 +++++++++++++
 tb/tb_mips_mem_arb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arb.sv
// Arbiter/sequencer for MIPS memory port 2 shared by the CPU load/store unit and a DMA/boot requester.
// Optional feature: define MEM_ARB_STARVE_EN to force a DMA grant after STARVE_LIMIT consecutive CPU grants.
module mips_mem_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [29:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_we,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_excpt,
    input  logic        dma_req,
    input  logic [29:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_we,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        dma_excpt,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [0:3]  mem_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_excpt
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic        grant_cpu, grant_dma, dma_force;
    logic        owner_dma;
    logic [29:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_we;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mips_mem_arb: STARVE_LIMIT must be in 1..15");
    end

`ifdef MEM_ARB_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    assign dma_force = (starve_cnt == LIMIT);

    // Counts CPU wins against a waiting DMA; any IDLE cycle without dma_req breaks the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!dma_req || grant_dma)
                starve_cnt <= '0;
            else if (grant_cpu && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign dma_force = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req && !(dma_req && dma_force)) grant_cpu = 1'b1;
                else if (dma_req)                         grant_dma = 1'b1;
                if (cpu_req || dma_req) state_nxt = ACCESS;
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // mem_we is [0:3]; map by lane index, not by position, and block writes in a reset cycle.
    always_comb begin
        mem_we = '0;
        if (state == ACCESS && !rst)
            for (int i = 0; i < 4; i++) mem_we[i] = lat_we[i];
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_dma <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            cpu_excpt <= 1'b0;
            dma_rdata <= '0;
            dma_excpt <= 1'b0;
        end else begin
            if (grant_cpu) begin
                owner_dma <= 1'b0;
                lat_addr  <= cpu_addr;
                lat_wdata <= cpu_wdata;
                lat_we    <= cpu_we;
            end else if (grant_dma) begin
                owner_dma <= 1'b1;
                lat_addr  <= dma_addr;
                lat_wdata <= dma_wdata;
                lat_we    <= dma_we;
            end
            cpu_ack <= (state == ACCESS) && !owner_dma;
            dma_ack <= (state == ACCESS) && owner_dma;
            if (state == ACCESS) begin
                if (owner_dma) begin
                    dma_rdata <= mem_rdata;
                    dma_excpt <= mem_excpt;
                end else begin
                    cpu_rdata <= mem_rdata;
                    cpu_excpt <= mem_excpt;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_arb.sv
// Directed self-checking bench for mips_mem_arb with a small behavioural port-2 memory.
module tb_mips_mem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, dma_req = 1'b0;
    logic [29:0] cpu_addr = '0, dma_addr = '0;
    logic [31:0] cpu_wdata = '0, dma_wdata = '0;
    logic [3:0]  cpu_we = '0, dma_we = '0;
    logic        cpu_ack, dma_ack, cpu_excpt, dma_excpt;
    logic [31:0] cpu_rdata, dma_rdata;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [0:3]  mem_we;
    logic        mem_excpt;
    logic [3:0]  mem_we_lane;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:255];
    logic        load_en = 1'b0;
    logic [7:0]  load_a = '0;
    logic [31:0] load_d = '0;

    always #5 clk = ~clk;

    mips_mem_arb #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_excpt(cpu_excpt),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_excpt(dma_excpt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_excpt(mem_excpt)
    );

    // Lane-indexed view of mem_we: bit i here is lane i.
    assign mem_we_lane = {mem_we[3], mem_we[2], mem_we[1], mem_we[0]};

    // 256-word memory; anything above is an address exception and is never written.
    assign mem_excpt = (mem_addr[29:8] != 22'd0);
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (load_en)
            mem[load_a] <= load_d;
        else if (!mem_excpt)
            for (int i = 0; i < 4; i++)
                if (mem_we[i]) mem[mem_addr[7:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        load_a = a; load_d = d; load_en = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    // Called and returns at 1 time unit after a rising edge; latency counted in negedges after req.
    task automatic do_access(input bit is_dma, input logic [29:0] a, input logic [31:0] wd,
                             input logic [3:0] we, output int lat, output logic [31:0] rd,
                             output logic ex, output int we_cyc, output logic [3:0] we_val,
                             output int other_acks);
        lat = -1; rd = '0; ex = 1'b0; we_cyc = 0; we_val = '0; other_acks = 0;
        if (is_dma) begin dma_addr = a; dma_wdata = wd; dma_we = we; dma_req = 1'b1; end
        else        begin cpu_addr = a; cpu_wdata = wd; cpu_we = we; cpu_req = 1'b1; end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_we_lane != 4'd0) begin we_cyc++; we_val = mem_we_lane; end
            if (is_dma ? cpu_ack : dma_ack) other_acks++;
            if (is_dma ? dma_ack : cpu_ack) begin
                lat = k;
                rd  = is_dma ? dma_rdata : cpu_rdata;
                ex  = is_dma ? dma_excpt : cpu_excpt;
                break;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; dma_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        preload(8'd0, 32'hCAFEF00D);
        preload(8'd1, 32'h01010101);
        preload(8'd2, 32'h02020202);
        preload(8'd5, 32'h11223344);
        preload(8'd7, 32'h55667788);
        preload(8'd16, 32'h12345678);
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack got %b want 0", cpu_ack); end
        checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL reset_dma_ack got %b want 0", dma_ack); end
        checks++; if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0/0", cpu_rdata, dma_rdata); end
        checks++; if (cpu_excpt !== 1'b0 || dma_excpt !== 1'b0) begin errors++; $display("FAIL reset_excpt got %b/%b want 0/0", cpu_excpt, dma_excpt); end
        checks++; if (mem_we_lane !== 4'h0) begin errors++; $display("FAIL reset_mem_we got %b want 0000", mem_we_lane); end
        checks++; if (mem_addr !== 30'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_cpu_read();
        int lat, wc, oa; logic [31:0] rd; logic ex; logic [3:0] wv;
        do_access(1'b0, 30'h10, 32'h0, 4'h0, lat, rd, ex, wc, wv, oa);
        checks++; if (lat !== 2) begin errors++; $display("FAIL cpu_read_latency got %0d want 2", lat); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL cpu_read_data got %h want 12345678", rd); end
        checks++; if (ex !== 1'b0) begin errors++; $display("FAIL cpu_read_excpt got %b want 0", ex); end
        checks++; if (wc !== 0) begin errors++; $display("FAIL cpu_read_no_we got %0d write cycles want 0", wc); end
        checks++; if (oa !== 0) begin errors++; $display("FAIL cpu_read_no_dma_ack got %0d want 0", oa); end
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL cpu_ack_single_pulse got %b want 0", cpu_ack); end
        checks++; if (cpu_rdata !== 32'h12345678) begin errors++; $display("FAIL cpu_rdata_hold got %h want 12345678", cpu_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_dma_write();
        int lat, wc, oa; logic [31:0] rd; logic ex; logic [3:0] wv;
        do_access(1'b1, 30'h5, 32'hAABBCCDD, 4'b0011, lat, rd, ex, wc, wv, oa);
        checks++; if (lat !== 2) begin errors++; $display("FAIL dma_write_latency got %0d want 2", lat); end
        checks++; if (wc !== 1) begin errors++; $display("FAIL dma_write_we_cycles got %0d want 1", wc); end
        checks++; if (wv !== 4'b0011) begin errors++; $display("FAIL dma_write_we_lanes got %b want 0011", wv); end
        checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL dma_write_prewrite_data got %h want 11223344", rd); end
        @(negedge clk);
        checks++; if (mem_addr !== 30'h5 || mem_wdata !== 32'hAABBCCDD) begin errors++; $display("FAIL mem_bus_hold got %h/%h want 5/aabbccdd", mem_addr, mem_wdata); end
        @(posedge clk); #1;
        do_access(1'b1, 30'h5, 32'h0, 4'h0, lat, rd, ex, wc, wv, oa);
        checks++; if (rd !== 32'h1122CCDD) begin errors++; $display("FAIL dma_readback got %h want 1122ccdd", rd); end
        checks++; if (oa !== 0) begin errors++; $display("FAIL dma_readback_no_cpu_ack got %0d want 0", oa); end
    endtask

    task automatic test_excpt();
        int lat, wc, oa; logic [31:0] rd; logic ex; logic [3:0] wv;
        do_access(1'b0, 30'h0001_0000, 32'hDEADBEEF, 4'hF, lat, rd, ex, wc, wv, oa);
        checks++; if (lat !== 2) begin errors++; $display("FAIL excpt_latency got %0d want 2", lat); end
        checks++; if (ex !== 1'b1) begin errors++; $display("FAIL excpt_flag got %b want 1", ex); end
        do_access(1'b1, 30'h0, 32'h0, 4'h0, lat, rd, ex, wc, wv, oa);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL excpt_word0_unchanged got %h want cafef00d", rd); end
        checks++; if (ex !== 1'b0) begin errors++; $display("FAIL excpt_word0_flag got %b want 0", ex); end
        checks++; if (cpu_excpt !== 1'b1) begin errors++; $display("FAIL cpu_excpt_hold got %b want 1", cpu_excpt); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] seq = '0;
        logic [9:0] exp_seq;
        int n = 0, last = -1, gap_bad = 0, both = 0;
`ifdef MEM_ARB_STARVE_EN
        exp_seq = 10'b10000_10000;
`else
        exp_seq = 10'b00000_00000;
`endif
        cpu_addr = 30'h1; cpu_we = 4'h0; dma_addr = 30'h2; dma_we = 4'h0;
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int k = 0; k < 60 && n < 10; k++) begin
            @(negedge clk);
            if (cpu_ack && dma_ack) both++;
            if (cpu_ack || dma_ack) begin
                seq[n] = dma_ack;
                if (last >= 0 && k - last != 3) gap_bad++;
                last = k;
                n++;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; dma_req = 1'b0;
        checks++; if (n !== 10) begin errors++; $display("FAIL b2b_ack_count got %0d want 10", n); end
        checks++; if (seq !== exp_seq) begin errors++; $display("FAIL b2b_grant_order got %b want %b (bit0 first, 1=DMA)", seq, exp_seq); end
        checks++; if (gap_bad !== 0) begin errors++; $display("FAIL b2b_spacing got %0d bad gaps want 0", gap_bad); end
        checks++; if (both !== 0) begin errors++; $display("FAIL b2b_dual_ack got %0d want 0", both); end
    endtask

    task automatic test_reset_mid();
        int lat = -1, wc, oa; logic [31:0] rd; logic ex; logic [3:0] wv;
        dma_addr = 30'h7; dma_wdata = 32'h0; dma_we = 4'hF; dma_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_we_lane !== 4'h0) begin errors++; $display("FAIL rst_mid_mem_we got %b want 0000", mem_we_lane); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (mem[7] !== 32'h55667788) begin errors++; $display("FAIL rst_mid_word_unchanged got %h want 55667788", mem[7]); end
        checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_no_ack got %b want 0", dma_ack); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dma_ack) begin lat = k; break; end
        end
        checks++; if (lat !== 2) begin errors++; $display("FAIL rst_mid_retry_latency got %0d want 2", lat); end
        checks++; if (dma_rdata !== 32'h55667788) begin errors++; $display("FAIL rst_mid_retry_data got %h want 55667788", dma_rdata); end
        @(posedge clk); #1;
        dma_req = 1'b0;
        do_access(1'b0, 30'h7, 32'h0, 4'h0, lat, rd, ex, wc, wv, oa);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mid_final_word got %h want 00000000", rd); end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_excpt();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
